// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc_pkg
// Description : Shared opcode encodings, width defaults and FSM state encoding
//               for the P32 multi-cycle execute-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_OPCODE = 5;

  localparam int ALU_OP_THA   = 0;
  localparam int ALU_OP_THB   = 1;
  localparam int ALU_OP_THA_B = 2;
  localparam int ALU_OP_THA_H = 3;
  localparam int ALU_OP_THB_B = 4;
  localparam int ALU_OP_THB_H = 5;
  localparam int ALU_OP_ADD   = 6;
  localparam int ALU_OP_SUB   = 7;
  localparam int ALU_OP_AND   = 8;
  localparam int ALU_OP_ORR   = 9;
  localparam int ALU_OP_XOR   = 10;
  localparam int ALU_OP_NOT   = 11;
  localparam int ALU_OP_SHL   = 12;
  localparam int ALU_OP_SHR   = 13;
  localparam int ALU_OP_MUL   = 14;
  localparam int ALU_OP_DIV   = 15;
  localparam int ALU_OP_MOD   = 16;
  localparam int ALU_OP_CMP   = 17;
  localparam int ALU_OP_CGE   = 18;
  localparam int ALU_OP_CGT   = 19;

  localparam logic [0:0] ALU_ST_IDLE = 1'b0;
  localparam logic [0:0] ALU_ST_BUSY = 1'b1;

  // Which iterative unit owns the pending result while BUSY.
  localparam logic [1:0] ALU_K_MUL = 2'd0;
  localparam logic [1:0] ALU_K_DIV = 2'd1;
  localparam logic [1:0] ALU_K_MOD = 2'd2;

  function automatic int alu_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_divider.sv
`default_nettype none
// ============================================================================
// Module      : alu_divider
// Description : Iterative restoring divider, one quotient bit per cycle,
//               start/done handshake. Built only when P32_ALU_DIV_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef P32_ALU_DIV_EN
module alu_divider
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int            CW       = alu_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;

  logic [WIDTH-1:0] src_rem, src_quo, src_dsr;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH:0]   shifted, diff;

  // The first iteration runs on the start edge straight from the operands,
  // so the final bit is registered after WIDTH-1 further edges.
  always_comb begin
    src_rem = start ? '0       : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dsr = start ? divisor  : dsr_q;
    shifted = {src_rem, src_quo[WIDTH-1]};
    diff    = shifted - {1'b0, src_dsr};
    if (!diff[WIDTH]) begin
      step_rem = diff[WIDTH-1:0];
      step_quo = {src_quo[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = shifted[WIDTH-1:0];
      step_quo = {src_quo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    if (start) begin
      rem_d    = step_rem;
      quo_d    = step_quo;
      dsr_d    = divisor;
      cnt_d    = CW'(1);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q != CNT_LAST) begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
      end else begin
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
    end
  end

  assign done      = active_q && (cnt_q == CNT_LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
`endif
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle P32 ALU with valid/ready handshakes, iterative
//               shift-add multiply and optional restoring divide
//               (enabled by P32_ALU_DIV_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPCODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   com,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             sign,
  output logic             zero,
  output logic             div_err
);

  localparam int               CW        = alu_cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             carry_q, carry_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             div_err_q, div_err_d;

  int               op;
  logic             accept, is_mul_op, is_multi;
  logic             mul_busy, mul_done, busy_done;
  logic [WIDTH-1:0] mc_out;
  logic             mc_err;
  logic [WIDTH-1:0] sc_out;
  logic             sc_carry, sc_sign, sc_zero, sc_err, flags_fixed;
  logic [WIDTH:0]   sum;

  always_comb op = int'(com);

  assign in_ready  = (state_q == ALU_ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul_op = (op == ALU_OP_MUL);
  assign mul_done  = (cnt_q == CNT_LAST);

`ifdef P32_ALU_DIV_EN
  logic [1:0]       kind_q, kind_d;
  logic             divz_q, divz_d;
  logic             is_div_op, div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign is_div_op = (op == ALU_OP_DIV) || (op == ALU_OP_MOD);
  assign is_multi  = is_mul_op || is_div_op;
  assign mul_busy  = (state_q == ALU_ST_BUSY) && (kind_q == ALU_K_MUL);
  assign div_start = accept && is_div_op;
  assign busy_done = (kind_q == ALU_K_MUL) ? mul_done : div_done;

  alu_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (in0),
    .divisor   (in1),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    kind_d = kind_q;
    divz_d = divz_q;
    if (accept && is_multi) begin
      kind_d = is_mul_op ? ALU_K_MUL : ((op == ALU_OP_DIV) ? ALU_K_DIV : ALU_K_MOD);
      divz_d = (in1 == '0);
    end
  end

  always_comb begin
    mc_out = acc_q;
    mc_err = 1'b0;
    case (kind_q)
      ALU_K_DIV: begin mc_out = div_quo; mc_err = divz_q; end
      ALU_K_MOD: begin mc_out = div_rem; mc_err = divz_q; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q <= ALU_K_MUL;
      divz_q <= 1'b0;
    end else begin
      kind_q <= kind_d;
      divz_q <= divz_d;
    end
  end
`else
  assign is_multi  = is_mul_op;
  assign mul_busy  = (state_q == ALU_ST_BUSY);
  assign busy_done = mul_done;
  assign mc_out    = acc_q;
  assign mc_err    = 1'b0;
`endif

  // Single-cycle datapath; compares and the disabled divider define their own flags.
  always_comb begin
    sc_out      = '0;
    sc_carry    = 1'b0;
    sc_sign     = 1'b0;
    sc_zero     = 1'b0;
    sc_err      = 1'b0;
    flags_fixed = 1'b0;
    sum         = {1'b0, in0} + {1'b0, in1};
    case (op)
      ALU_OP_THA, ALU_OP_THA_B, ALU_OP_THA_H: sc_out = in0;
      ALU_OP_THB, ALU_OP_THB_B, ALU_OP_THB_H: sc_out = in1;
      ALU_OP_ADD: begin
        sc_out   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
      end
      ALU_OP_SUB: begin
        sc_out   = in0 - in1;
        sc_carry = (in0 >= in1);
      end
      ALU_OP_AND: sc_out = in0 & in1;
      ALU_OP_ORR: sc_out = in0 | in1;
      ALU_OP_XOR: sc_out = in0 ^ in1;
      ALU_OP_NOT: sc_out = ~in0;
      ALU_OP_SHL: sc_out = (in1 >= SHIFT_LIM) ? '0 : (in0 << in1);
      ALU_OP_SHR: sc_out = (in1 >= SHIFT_LIM) ? '0 : (in0 >> in1);
      ALU_OP_DIV, ALU_OP_MOD: begin
        sc_zero     = 1'b1;
        sc_err      = 1'b1;
        flags_fixed = 1'b1;
      end
      ALU_OP_CMP, ALU_OP_CGE: begin
        sc_out      = in0;
        sc_carry    = (in0 >= in1);
        sc_zero     = (in0 == in1);
        sc_sign     = (in0 < in1);
        flags_fixed = 1'b1;
      end
      ALU_OP_CGT: begin
        sc_out      = in0;
        sc_carry    = (in0 > in1);
        sc_zero     = (in0 == in1);
        sc_sign     = (in0 <= in1);
        flags_fixed = 1'b1;
      end
      default: flags_fixed = 1'b1;
    endcase
    if (!flags_fixed) begin
      sc_zero = (sc_out == '0);
      sc_sign = sc_out[WIDTH-1];
    end
  end

  // Shift-add multiplier: bit 0 of b is consumed on the accept edge.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (accept && is_mul_op) begin
      acc_d    = in1[0] ? in0 : '0;
      mcand_d  = in0 << 1;
      mplier_d = in1 >> 1;
      cnt_d    = CW'(1);
    end else if (mul_busy) begin
      if (!mul_done) begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    carry_d     = carry_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    div_err_d   = div_err_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      ALU_ST_IDLE: begin
        if (accept) begin
          if (is_multi) begin
            state_d = ALU_ST_BUSY;
          end else begin
            out_d       = sc_out;
            carry_d     = sc_carry;
            sign_d      = sc_sign;
            zero_d      = sc_zero;
            div_err_d   = sc_err;
            out_valid_d = 1'b1;
          end
        end
      end
      ALU_ST_BUSY: begin
        if (busy_done) begin
          state_d     = ALU_ST_IDLE;
          out_d       = mc_out;
          carry_d     = 1'b0;
          sign_d      = mc_out[WIDTH-1];
          zero_d      = (mc_out == '0);
          div_err_d   = mc_err;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ALU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALU_ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      div_err_q   <= div_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign carry     = carry_q;
  assign sign      = sign_q;
  assign zero      = zero_q;
  assign div_err   = div_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Self-checking bench for alu_mc: directed vector table,
//               handshake corner sequences and randomized model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]    com;
  logic [W-1:0]  in0, in1, out;
  logic          carry, sign, zero, div_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          op;
    logic [31:0] a, b, o;
    logic        c, s, z, e;
  } vec_t;

  vec_t vecs[$];

  alu_mc #(.WIDTH(W), .OPW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .com(com), .in0(in0), .in1(in1), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .carry(carry), .sign(sign),
    .zero(zero), .div_err(div_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input logic [31:0] a, b, o,
                              input logic c, s, z, e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.o = o;
    v.c = c; v.s = s; v.z = z; v.e = e;
    return v;
  endfunction

  function automatic logic [31:0] flags_of(input vec_t v);
    return {28'd0, v.c, v.s, v.z, v.e};
  endfunction

  // Reference behaviour computed directly from the opcode definitions.
  function automatic vec_t model(input int op, input logic [31:0] a, b);
    vec_t        m;
    bit          fixed;
    logic [63:0] wide;
    m = mk(op, a, b, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    fixed = 1'b0;
    case (op)
      ALU_OP_THA, ALU_OP_THA_B, ALU_OP_THA_H: m.o = a;
      ALU_OP_THB, ALU_OP_THB_B, ALU_OP_THB_H: m.o = b;
      ALU_OP_ADD: begin
        wide = 64'(a) + 64'(b);
        m.o  = wide[31:0];
        m.c  = (wide > 64'h0000_0000_FFFF_FFFF);
      end
      ALU_OP_SUB: begin m.o = a - b; m.c = (a >= b); end
      ALU_OP_AND: m.o = a & b;
      ALU_OP_ORR: m.o = a | b;
      ALU_OP_XOR: m.o = a ^ b;
      ALU_OP_NOT: m.o = ~a;
      ALU_OP_SHL: m.o = (b >= 32) ? 32'd0 : (a << b);
      ALU_OP_SHR: m.o = (b >= 32) ? 32'd0 : (a >> b);
      ALU_OP_MUL: begin wide = 64'(a) * 64'(b); m.o = wide[31:0]; end
      ALU_OP_DIV, ALU_OP_MOD: begin
`ifdef P32_ALU_DIV_EN
        if (b == 0) begin
          m.o = (op == ALU_OP_DIV) ? 32'hFFFF_FFFF : a;
          m.e = 1'b1;
        end else begin
          m.o = (op == ALU_OP_DIV) ? (a / b) : (a % b);
        end
`else
        m.z = 1'b1; m.e = 1'b1; fixed = 1'b1;
`endif
      end
      ALU_OP_CMP, ALU_OP_CGE: begin
        m.o = a; m.c = (a >= b); m.z = (a == b); m.s = (a < b); fixed = 1'b1;
      end
      ALU_OP_CGT: begin
        m.o = a; m.c = (a > b); m.z = (a == b); m.s = (a <= b); fixed = 1'b1;
      end
      default: fixed = 1'b1;
    endcase
    if (!fixed) begin
      m.z = (m.o == 32'd0);
      m.s = m.o[31];
    end
    return m;
  endfunction

  function automatic int exp_extra(input int op);
    if (op == ALU_OP_MUL) return W;
`ifdef P32_ALU_DIV_EN
    if (op == ALU_OP_DIV || op == ALU_OP_MOD) return W;
`endif
    return 0;
  endfunction

  // Issue one op, scramble the inputs after acceptance, wait for the result.
  task automatic run_op(input int op, input logic [31:0] a, b,
                        output vec_t got, output int extra, output bit rdy_ok);
    int guard;
    @(negedge clk);
    com = 5'(op); in0 = a; in1 = b; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    com = 5'($urandom); in0 = $urandom; in1 = $urandom;
    extra  = 0;
    rdy_ok = 1'b1;
    while (!out_valid && extra < 100) begin
      if (in_ready) rdy_ok = 1'b0;
      @(posedge clk);
      #1;
      extra++;
    end
    got = mk(op, a, b, out, carry, sign, zero, div_err);
  endtask

  task automatic check_op(input string tag, input vec_t exp);
    vec_t got;
    int   extra;
    bit   rdy_ok;
    int   lat;
    run_op(exp.op, exp.a, exp.b, got, extra, rdy_ok);
    lat = exp_extra(exp.op);
    chk($sformatf("%s op%0d a=%h b=%h out", tag, exp.op, exp.a, exp.b), got.o, exp.o);
    chk($sformatf("%s op%0d flags(c,s,z,e)", tag, exp.op), flags_of(got), flags_of(exp));
    chk($sformatf("%s op%0d latency", tag, exp.op), 32'(extra), 32'(lat));
    if (lat > 0) chk($sformatf("%s op%0d in_ready low while busy", tag, exp.op), 32'(rdy_ok), 32'd1);
  endtask

  initial begin
    vec_t got;
    int   extra;
    bit   rdy_ok;
    bit   quiet;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    com = '0; in0 = '0; in1 = '0;

    vecs.push_back(mk(ALU_OP_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0));
    vecs.push_back(mk(ALU_OP_SUB,   32'd3,         32'd5,         32'hFFFF_FFFE, 0, 1, 0, 0));
    vecs.push_back(mk(ALU_OP_SUB,   32'd5,         32'd3,         32'd2,         1, 0, 0, 0));
    vecs.push_back(mk(ALU_OP_AND,   32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h00F0_00FF, 0, 0, 0, 0));
    vecs.push_back(mk(ALU_OP_ORR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0, 0, 0));
    vecs.push_back(mk(ALU_OP_XOR,   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 0, 1, 0, 0));
    vecs.push_back(mk(ALU_OP_NOT,   32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 0, 0, 1, 0));
    vecs.push_back(mk(ALU_OP_SHL,   32'd1,         32'd31,        32'h8000_0000, 0, 1, 0, 0));
    vecs.push_back(mk(ALU_OP_SHL,   32'd1,         32'd32,        32'h0000_0000, 0, 0, 1, 0));
    vecs.push_back(mk(ALU_OP_SHR,   32'h8000_0000, 32'd31,        32'h0000_0001, 0, 0, 0, 0));
    vecs.push_back(mk(ALU_OP_THB_H, 32'd1,         32'hABCD_1234, 32'hABCD_1234, 0, 1, 0, 0));
    vecs.push_back(mk(ALU_OP_CMP,   32'd2,         32'd5,         32'd2,         0, 1, 0, 0));
    vecs.push_back(mk(ALU_OP_CGE,   32'd5,         32'd2,         32'd5,         1, 0, 0, 0));
    vecs.push_back(mk(ALU_OP_CGT,   32'd7,         32'd3,         32'd7,         1, 0, 0, 0));
    vecs.push_back(mk(31,           32'd5,         32'd5,         32'd0,         0, 0, 0, 0));
    vecs.push_back(mk(ALU_OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, 0, 1, 0));
    vecs.push_back(mk(ALU_OP_MUL,   32'd7,         32'd6,         32'd42,        0, 0, 0, 0));
    vecs.push_back(mk(ALU_OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0));
`ifdef P32_ALU_DIV_EN
    vecs.push_back(mk(ALU_OP_DIV,   32'd100,       32'd7,         32'd14,        0, 0, 0, 0));
    vecs.push_back(mk(ALU_OP_MOD,   32'd100,       32'd7,         32'd2,         0, 0, 0, 0));
    vecs.push_back(mk(ALU_OP_DIV,   32'd5,         32'd0,         32'hFFFF_FFFF, 0, 1, 0, 1));
    vecs.push_back(mk(ALU_OP_MOD,   32'd5,         32'd0,         32'd5,         0, 0, 0, 1));
`else
    vecs.push_back(mk(ALU_OP_DIV,   32'd100,       32'd7,         32'd0,         0, 0, 1, 1));
    vecs.push_back(mk(ALU_OP_MOD,   32'd100,       32'd7,         32'd0,         0, 0, 1, 1));
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out",       out,            32'd0);
    chk("reset flags",     {28'd0, carry, sign, zero, div_err}, 32'd0);
    chk("reset in_ready",  32'(in_ready),  32'd1);

    foreach (vecs[i]) check_op("table", vecs[i]);

    // CGT result held under back-pressure with a SUB queued behind it.
    check_op("hold", mk(ALU_OP_CGT, 32'd3, 32'd3, 32'd3, 0, 1, 1, 0));
    @(negedge clk);
    com = 5'(ALU_OP_SUB); in0 = 32'd3; in1 = 32'd5; in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold cycle %0d out", k), out, 32'd3);
      chk($sformatf("hold cycle %0d flags", k), {28'd0, carry, sign, zero, div_err}, 32'h6);
      chk($sformatf("hold cycle %0d in_ready", k), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("queued sub out_valid", 32'(out_valid), 32'd1);
    chk("queued sub out",       out,            32'hFFFF_FFFE);
    chk("queued sub flags",     {28'd0, carry, sign, zero, div_err}, 32'h4);

    // Reset during MUL busy cycle 10 aborts it.
    @(negedge clk);
    com = 5'(ALU_OP_MUL); in0 = 32'd123; in1 = 32'd456; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort out",       out,            32'd0);
    chk("abort flags",     {28'd0, carry, sign, zero, div_err}, 32'd0);
    chk("abort in_ready",  32'(in_ready),  32'd1);
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) quiet = 1'b0;
    end
    chk("abort no late result", 32'(quiet), 32'd1);
    check_op("post-abort", mk(ALU_OP_ADD, 32'd2, 32'd2, 32'd4, 0, 0, 0, 0));

    // Randomized ops against the reference model.
    for (int r = 0; r < 40; r++) begin
      int          op;
      logic [31:0] a, b;
      op = $urandom_range(0, 31);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(0, 40);
        2:       b = 32'd0;
        default: b = a;
      endcase
      check_op("random", model(op, a, b));
    end

    // Back-to-back single-cycle throughput: one result per cycle.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      com = 5'(ALU_OP_ADD); in0 = 32'(k * 10); in1 = 32'd1;
      @(posedge clk);
      #1;
      chk($sformatf("b2b %0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("b2b %0d out", k), out, 32'(k * 10 + 1));
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
